// File: rtl/uart_tx_param.sv
// Parameterised UART transmitter with a valid/ready payload input.
// Define UART_TX_CRC4_EN to append a CRC-4 (x^4+x+1) after data/parity.
module uart_tx_param #(
    parameter int CLKS_PER_BIT = 1042,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] s_data,
    input  logic                 s_valid,
    output logic                 s_ready,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_done
);
    localparam int CW = $clog2(CLKS_PER_BIT);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
`ifdef UART_TX_CRC4_EN
        CRC    = 3'd4,
`endif
        STOP   = 3'd5
    } state_t;

    state_t               state;
    logic [CW-1:0]        cnt;
    logic [3:0]           idx;
    logic [DATA_BITS-1:0] sh;
    logic                 par;
    logic                 bit_end;
    logic                 last_data;
    logic                 last_stop;
`ifdef UART_TX_CRC4_EN
    logic [3:0]           crc;
    logic [3:0]           crc_nx;
    logic                 fb;
`endif

    assign s_ready   = (state == IDLE) && !rst;
    assign bit_end   = (cnt == CW'(CLKS_PER_BIT - 1));
    assign last_data = (idx == 4'(DATA_BITS - 1));
    assign last_stop = (idx == 4'(STOP_BITS - 1));

`ifdef UART_TX_CRC4_EN
    // sh[0] is the data bit currently on the line
    assign fb     = crc[3] ^ sh[0];
    assign crc_nx = {crc[2:0], 1'b0} ^ (fb ? 4'b0011 : 4'b0000);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            idx     <= '0;
            sh      <= '0;
            par     <= 1'b0;
            tx      <= 1'b1;
            tx_busy <= 1'b0;
            tx_done <= 1'b0;
`ifdef UART_TX_CRC4_EN
            crc     <= '0;
`endif
        end else begin
            tx_done <= 1'b0;
            cnt     <= bit_end ? '0 : cnt + 1'b1;
            case (state)
                IDLE: begin
                    cnt     <= '0;
                    idx     <= '0;
                    tx      <= 1'b1;
                    tx_busy <= 1'b0;
                    if (s_valid && s_ready) begin
                        sh      <= s_data;
                        par     <= (^s_data) ^ (PARITY_MODE == 2);
`ifdef UART_TX_CRC4_EN
                        crc     <= '0;
`endif
                        state   <= START;
                        tx      <= 1'b0;
                        tx_busy <= 1'b1;
                    end
                end
                START: begin
                    if (bit_end) begin
                        state <= DATA;
                        tx    <= sh[0];
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        sh <= sh >> 1;
`ifdef UART_TX_CRC4_EN
                        crc <= crc_nx;
`endif
                        if (last_data) begin
                            idx <= '0;
                            if (PARITY_MODE != 0) begin
                                state <= PARITY;
                                tx    <= par;
                            end else begin
`ifdef UART_TX_CRC4_EN
                                state <= CRC;
                                tx    <= crc_nx[3];
`else
                                state <= STOP;
                                tx    <= 1'b1;
`endif
                            end
                        end else begin
                            idx <= idx + 1'b1;
                            tx  <= sh[1];
                        end
                    end
                end
                PARITY: begin
                    if (bit_end) begin
`ifdef UART_TX_CRC4_EN
                        state <= CRC;
                        tx    <= crc[3];
`else
                        state <= STOP;
                        tx    <= 1'b1;
`endif
                    end
                end
`ifdef UART_TX_CRC4_EN
                CRC: begin
                    if (bit_end) begin
                        crc <= {crc[2:0], 1'b0};
                        if (idx == 4'd3) begin
                            idx   <= '0;
                            state <= STOP;
                            tx    <= 1'b1;
                        end else begin
                            idx <= idx + 1'b1;
                            tx  <= crc[2];
                        end
                    end
                end
`endif
                STOP: begin
                    if (bit_end) begin
                        if (last_stop) begin
                            idx     <= '0;
                            state   <= IDLE;
                            tx_busy <= 1'b0;
                            tx_done <= 1'b1;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    cnt     <= '0;
                    idx     <= '0;
                    tx      <= 1'b1;
                    tx_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_tx_param.md
UART_TX_PARAM -- requirements
Module: uart_tx_param

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 1042, meaning clock cycles per serial bit (legal range >= 2).
REQ-002 The block SHALL have parameter DATA_BITS, default 8, meaning payload bits per frame (legal range 5..9).
REQ-003 The block SHALL have parameter PARITY_MODE, default 0, meaning 0 none, 1 even, 2 odd.
REQ-004 The block SHALL have parameter STOP_BITS, default 1, meaning stop bits per frame (legal range 1..2).
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 The block SHALL have port s_data, input, DATA_BITS bits: payload, sampled only on handshake.
REQ-008 The block SHALL have port s_valid, input, 1 bit: payload valid.
REQ-009 The block SHALL have port s_ready, output, 1 bit: block can accept a payload.
REQ-010 The block SHALL have port tx, output, 1 bit: serial line, idle high.
REQ-011 The block SHALL have port tx_busy, output, 1 bit: frame in progress.
REQ-012 The block SHALL have port tx_done, output, 1 bit: one-cycle frame-complete pulse.

Function
REQ-013 The FSM SHALL have the states IDLE, START, DATA, PARITY, CRC, STOP; DATA→PARITY→CRC→STOP, with PARITY skipped when PARITY_MODE=0 and CRC skipped when compiled out.
REQ-014 s_ready SHALL be high exactly when the state is IDLE and rst is low; a handshake is s_valid && s_ready in the same cycle.
REQ-015 On a handshake, s_data SHALL be latched into an internal shift register; later changes to s_data SHALL NOT affect the frame.
REQ-016 After a handshake in cycle N, tx SHALL be 0 (start bit) from cycle N+1.
REQ-017 Each bit SHALL hold tx for exactly CLKS_PER_BIT cycles, counted by a counter of width $clog2(CLKS_PER_BIT) that wraps to 0 on every bit boundary.
REQ-018 Data SHALL be sent LSB first: DATA_BITS bits, then parity if enabled, then CRC if compiled in, then STOP_BITS high bits.
REQ-019 Parity SHALL be the XOR of the payload for even mode, and its inverse for odd mode.
REQ-020 In IDLE, tx SHALL be 1.
REQ-021 At the end of the final stop bit, the state SHALL return to IDLE and tx_done SHALL be 1 for exactly that first IDLE cycle.
REQ-022 tx_busy SHALL be 1 in every non-IDLE state.
REQ-023 The minimum frame-to-frame period SHALL be (1 + DATA_BITS + P + C + STOP_BITS)*CLKS_PER_BIT + 1 cycles, where P is 0 or 1 for parity and C is 0 or 4 for CRC.
REQ-024 s_valid asserted while busy SHALL be ignored until s_ready is high; no payload SHALL be lost or duplicated.
REQ-025 An illegal state encoding SHALL return the FSM to IDLE with tx=1 on the next cycle.

Reset
REQ-026 While rst=1, outputs SHALL be registered to tx=1, s_ready=0, tx_busy=0, tx_done=0, with the FSM in IDLE and the counter, bit index and CRC at 0.
REQ-027 rst asserted mid-frame SHALL abort the frame: tx=1 from the next cycle, with no tx_done pulse.
REQ-028 rst SHALL take priority over a simultaneous handshake; the payload is dropped.

Configuration
REQ-029 With macro UART_TX_CRC4_EN defined, a 4-bit CRC over the payload SHALL be sent after data/parity and before stop.
REQ-030 The CRC SHALL use polynomial x^4+x+1 with init 0, updated serially per payload bit in send order: fb=crc[3]^d; crc={crc[2:0],0}^(fb?4'b0011:0).
REQ-031 The CRC SHALL be sent MSB first.
REQ-032 Without UART_TX_CRC4_EN, no CRC logic or CRC state SHALL exist and frames SHALL be plain UART.

Verification (CLKS_PER_BIT=4, DATA_BITS=8)
REQ-033 Scenario 1, no parity, CRC out: s_data=8'hA5, one-cycle s_valid → tx = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles; tx_done pulses at cycle N+41.
REQ-034 Scenario 2, CRC in, no parity: s_data=8'h01 → CRC bits 1,1,1,0 follow the data bits; tx_done at N+57.
REQ-035 Scenario 3, PARITY_MODE=1 then 2, STOP_BITS=2: s_data=8'h01 → parity bit 1 (even) or 0 (odd), then 8 cycles of high stop.
REQ-036 Scenario 4: s_valid held high with s_data changing every cycle during a frame → exactly one frame per handshake; the second frame starts 1 cycle after tx_done.
REQ-037 Scenario 5: rst pulsed in the DATA state → tx=1 on the next cycle, no tx_done, s_ready=1 the cycle after rst drops.
